ram_sp_init: RTL and testbench

Parametrised single-port synchronous RAM with per-byte write enables, registered 1-cycle read with a valid strobe, and a built-in clear engine. The clear engine zeroes every word after reset or on request. It is the next-generation replacement for the fixed 256 x 64 RAM in the memory subsystem, with the same cen/wen/addr/din/dout access style.

---
 rtl/ram_sp_init.sv | 112 +++++++++++
 tb/tb_ram_sp_init.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ram_sp_init.sv
// Single-port synchronous RAM with per-byte write enables, a registered 1-cycle read and
// a clear engine that zeroes every word after reset or on a soft clear request.
module ram_sp_init #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    cen,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    rvalid,
    output logic                    ready,
    output logic                    acc_err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    rvalid_q, rvalid_d;
    logic                    acc_err_q, acc_err_d;
    logic                    rd_en;
    logic [BE_W-1:0]         wr_be;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // A pending clr outranks both the clear sweep and user traffic; the port is shared.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        acc_err_d = 1'b0;
        rd_en     = 1'b0;
        wr_be     = '0;
        wr_addr   = addr;
        wr_data   = din;
        if (clr) begin
            state_d   = CLEAR;
            cnt_d     = '0;
            acc_err_d = cen;
        end else if (state_q == CLEAR) begin
            acc_err_d = cen;
            wr_be     = '1;
            wr_addr   = cnt_q;
            wr_data   = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = IDLE;
            end
        end else if (cen) begin
            if (wen) begin
                wr_be = be;
            end else begin
                rd_en    = 1'b1;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            acc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            acc_err_q <= acc_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_en) begin
            dout_q <= mem[addr];
        end
    end

    // The reset edge never touches the array; the following sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign dout    = dout_q;
    assign rvalid  = rvalid_q;
    assign acc_err = acc_err_q;
    assign ready   = (state_q == IDLE);

endmodule

// File: tb/tb_ram_sp_init.sv
// Bench for ram_sp_init: directed scenarios plus randomized traffic against a
// behavioural model (word array, remaining-clear-edge counter, output registers).
module tb_ram_sp_init;

    localparam int DW    = 64;
    localparam int AW    = 8;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, clr, cen, wen;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rvalid, ready, acc_err;

    ram_sp_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cen(cen), .wen(wen), .be(be),
        .addr(addr), .din(din), .dout(dout), .rvalid(rvalid), .ready(ready),
        .acc_err(acc_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_busy = DEPTH;
    logic [DW-1:0] m_dout = '0;
    logic          m_rvalid = 1'b0;
    logic          m_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_wipe();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    // One clock edge: drive, update the model with the same inputs, compare.
    task automatic cyc(input logic r, input logic c, input logic e, input logic w,
                       input logic [BW-1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst = r; clr = c; cen = e; wen = w; be = b; addr = a; din = d;
        @(posedge clk);
        m_rvalid = 1'b0;
        m_acc    = 1'b0;
        if (r) begin
            m_busy = DEPTH; m_dout = '0; m_wipe();
        end else if (c) begin
            m_busy = DEPTH; m_acc = e; m_wipe();
        end else if (m_busy > 0) begin
            m_busy--; m_acc = e;
        end else if (e) begin
            if (w) begin
                for (int i = 0; i < BW; i++)
                    if (b[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
            end else begin
                m_dout = m_mem[a]; m_rvalid = 1'b1;
            end
        end
        #1;
        check("ready", 64'(ready), 64'(m_busy == 0));
        check("rvalid", 64'(rvalid), 64'(m_rvalid));
        check("acc_err", 64'(acc_err), 64'(m_acc));
        check("dout", dout, m_dout);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        cyc(0, 0, 1, 1, b, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(0, 0, 1, 0, '0, a, $urandom);
    endtask

    // Counts idle edges until ready rises, bounded, and checks the count.
    task automatic wait_ready(input int exp_edges);
        int n = 0;
        while (!ready && n < DEPTH + 50) begin
            idle();
            n++;
        end
        check("clear_len", 64'(n), 64'(exp_edges));
    endtask

    initial begin
        m_wipe();
        // Reset and full clear
        cyc(1, 0, 0, 0, '0, '0, '0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_dout", dout, 64'd0);
        cyc(1, 0, 1, 0, '0, 8'h03, '0);
        wait_ready(DEPTH);
        rd(8'h00); rd(8'h7F); rd(8'hFF);
        check("zero_ff", dout, 64'd0);

        // Full writes, back-to-back reads, hold on cen=0
        wr(8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(8'h01, 64'h1234_5678_1234_5678, 8'hFF);
        rd(8'h00);
        check("rd00", dout, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(8'h01);
        check("rd01", dout, 64'h1234_5678_1234_5678);
        check("rd01_vld", 64'(rvalid), 64'd1);
        idle(); idle();
        check("hold", dout, 64'h1234_5678_1234_5678);

        // Byte enables
        wr(8'h10, 64'h1122_3344_5566_7788, 8'hFF);
        wr(8'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        rd(8'h10);
        check("be_merge", dout, 64'h1122_3344_AAAA_AAAA);
        wr(8'h10, 64'h0, 8'h00);
        rd(8'h10);
        check("be_none", dout, 64'h1122_3344_AAAA_AAAA);

        // Access during clear
        wr(8'h05, 64'h5555_0000_5555_0000, 8'hFF);
        cyc(1, 0, 0, 0, '0, '0, '0);
        rd(8'h05);
        check("clr_rd_err", 64'(acc_err), 64'd1);
        wr(8'h05, 64'h1, 8'hFF);
        check("clr_wr_err", 64'(acc_err), 64'd1);
        wait_ready(DEPTH - 2);
        rd(8'h05);
        check("after_clr05", dout, 64'd0);

        // Soft clear with a colliding access
        wr(8'hFF, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        cyc(0, 1, 1, 0, '0, 8'hFF, '0);
        check("soft_err", 64'(acc_err), 64'd1);
        check("soft_ready", 64'(ready), 64'd0);
        wait_ready(DEPTH);
        rd(8'hFF);
        check("soft_ff", dout, 64'd0);

        // Reset mid-clear and mid-read
        cyc(1, 0, 0, 0, '0, '0, '0);
        repeat (100) idle();
        cyc(1, 0, 0, 0, '0, '0, '0);
        wait_ready(DEPTH);
        wr(8'h01, 64'hCAFE_F00D_0123_4567, 8'hFF);
        rd(8'h01);
        cyc(1, 0, 1, 0, '0, 8'h01, '0);
        check("rst_rd_dout", dout, 64'd0);
        check("rst_rd_vld", 64'(rvalid), 64'd0);
        wait_ready(DEPTH);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic          r, c, e, w;
            logic [AW-1:0] a;
            r = ($urandom_range(0, 1499) == 0);
            c = ($urandom_range(0, 699) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            cyc(r, c, e, w, BW'($urandom), a, {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
